// File: rtl/t03_pkg.sv
// t03_pkg: shared types and constants for the team_03 RV32I core.
// Holds the instruction-format enum, the fetch FSM state enum, base opcodes,
// the funct3 codes the control unit decodes (FOP_* for ALU ops, BR_* for
// branches), and the reset instruction word.
package t03_pkg;

  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } itype_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU funct3 codes
  localparam logic [2:0] FOP_ADD  = 3'b000;
  localparam logic [2:0] FOP_SLL  = 3'b001;
  localparam logic [2:0] FOP_SLT  = 3'b010;
  localparam logic [2:0] FOP_SLTU = 3'b011;
  localparam logic [2:0] FOP_XOR  = 3'b100;
  localparam logic [2:0] FOP_SR   = 3'b101;
  localparam logic [2:0] FOP_OR   = 3'b110;
  localparam logic [2:0] FOP_AND  = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // funct7 is part of the key only where it selects the operation:
  // register-register ops and the immediate shifts.
  function automatic logic key_uses_funct7(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_REG) || ((op == OP_IMM) && ((f3 == FOP_SLL) || (f3 == FOP_SR)));
  endfunction

endpackage

// File: rtl/t03_fetch_decode_if.sv
// t03_fetch_decode_if: request/acknowledge instruction-memory port.
//   imem_req   : fetch request, held until ack (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_ack   : imem_rdata valid this cycle (slave -> master)
//   imem_rdata : instruction word (slave -> master)
interface t03_fetch_decode_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/t03_imm_gen.sv
// t03_imm_gen: RV32I immediate generator.
//   instr  : instruction word
//   i_type : instruction format
//   imm    : sign-extended immediate (0 for R-type)
module t03_imm_gen
  import t03_pkg::*;
(
  input  logic [31:0] instr,
  input  itype_e      i_type,
  output logic [31:0] imm
);

  // Format-dependent immediate assembly, sign bit is always instr[31]
  always_comb begin
    imm = 32'd0;
    case (i_type)
      IT_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IT_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IT_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IT_U:    imm = {instr[31:12], 12'd0};
      IT_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/t03_fetch_decode.sv
// t03_fetch_decode: fetch and pre-decode stage.
//   clk, rst           : clock, asynchronous active-high reset
//   imem (master)      : instruction-memory req/ack port
//   retire, next_pc    : load next_pc (word-aligned) into pc from READY
//   pc                 : address of the held instruction
//   instr_valid        : decode outputs valid
//   instruction        : control key {funct7, funct3, opcode}
//   i_type             : instruction format
//   rs1, rs2, rd       : raw register index fields
//   imm                : sign-extended immediate
//   illegal            : opcode outside the supported set
//   misaligned         : last next_pc had low bits set
module t03_fetch_decode
  import t03_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  t03_fetch_decode_if.master   imem,
  input  logic                 retire,
  input  logic [31:0]          next_pc,
  output logic [31:0]          pc,
  output logic                 instr_valid,
  output logic [16:0]          instruction,
  output logic [2:0]           i_type,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [31:0]          imm,
  output logic                 illegal,
  output logic                 misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic         mis_q, mis_d;

  logic [6:0]   opcode_s;
  logic [2:0]   funct3_s;
  logic [2:0]   key_f3_s;
  logic [6:0]   key_f7_s;
  itype_e       itype_s;
  logic         illegal_s;

  // Fetch FSM next-state; req/valid are derived from the next state so they come out of flops
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ST_READY;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_READY: begin
        if (retire) begin
          pc_d    = {next_pc[31:2], 2'b00};
          mis_d   = |next_pc[1:0];
          state_d = ST_FETCH;
        end else begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_READY);
  end

  // FSM, PC and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign opcode_s = instr_q[6:0];
  assign funct3_s = instr_q[14:12];

  // Format classification and control-key formation from the held word
  always_comb begin
    itype_s   = IT_R;
    illegal_s = 1'b0;
    case (opcode_s)
      OP_REG:                    itype_s = IT_R;
      OP_IMM, OP_LOAD, OP_JALR:  itype_s = IT_I;
      OP_STORE:                  itype_s = IT_S;
      OP_BRANCH:                 itype_s = IT_B;
      OP_LUI, OP_AUIPC:          itype_s = IT_U;
      OP_JAL:                    itype_s = IT_J;
      default:                   illegal_s = 1'b1;
    endcase
    // U/J formats carry immediate bits where funct3 would be
    if ((opcode_s == OP_LUI) || (opcode_s == OP_AUIPC) || (opcode_s == OP_JAL)) begin
      key_f3_s = 3'd0;
    end else begin
      key_f3_s = funct3_s;
    end
    if (key_uses_funct7(opcode_s, funct3_s)) begin
      key_f7_s = instr_q[31:25];
    end else begin
      key_f7_s = 7'd0;
    end
  end

  t03_imm_gen u_imm_gen (
    .instr  (instr_q),
    .i_type (itype_s),
    .imm    (imm)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr_valid    = valid_q;
  assign misaligned     = mis_q;
  assign instruction    = illegal_s ? 17'd0 : {key_f7_s, key_f3_s, opcode_s};
  assign i_type         = itype_s;
  assign illegal        = illegal_s;
  assign rs1            = instr_q[19:15];
  assign rs2            = instr_q[24:20];
  assign rd             = instr_q[11:7];

endmodule
